// File: rtl/mul_seq_ctrl.sv
// Sequential RV64 M-extension multiplier: four XLEN/2 partial products accumulated into a 2*XLEN sum.
// Optional MUL_EARLY_OUT_EN: skip steps 1..3 when both magnitudes fit in XLEN/2 bits.
module mul_seq_ctrl #(
  parameter int XLEN    = 64,
  parameter int USE_DSP = 0,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HW = XLEN / 2;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  state_t             state;
  logic [1:0]         step;
  logic [2*XLEN-1:0]  acc;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               neg, is_w;
  logic [1:0]         op_r;
  logic [TAG_W-1:0]   tag_r;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Accept-side operand conditioning: MULW sign-extension, sign flags, magnitudes.
  logic            w_in, sa_in, sb_in;
  logic [XLEN-1:0] a_ext, b_ext, mag_a_in, mag_b_in;

  always_comb begin
    w_in     = in_word && (in_op == OP_MUL);
    a_ext    = w_in ? {{(XLEN-32){in_a[31]}}, in_a[31:0]} : in_a;
    b_ext    = w_in ? {{(XLEN-32){in_b[31]}}, in_b[31:0]} : in_b;
    sa_in    = a_ext[XLEN-1] && (in_op == OP_MULH || in_op == OP_MULHSU || w_in);
    sb_in    = b_ext[XLEN-1] && (in_op == OP_MULH || w_in);
    mag_a_in = sa_in ? -a_ext : a_ext;
    mag_b_in = sb_in ? -b_ext : b_ext;
  end

`ifdef MUL_EARLY_OUT_EN
  logic early;
  logic early_in;
  assign early_in = (mag_a_in[XLEN-1:HW] == '0) && (mag_b_in[XLEN-1:HW] == '0);
`endif

  // Step 0: aL*bL, 1: aL*bH, 2: aH*bL, 3: aH*bH.
  logic [HW-1:0]     op_a, op_b;
  logic [XLEN-1:0]   prod;
  logic [2*XLEN-1:0] partial;

  always_comb begin
    op_a = step[1] ? mag_a[XLEN-1:HW] : mag_a[HW-1:0];
    op_b = step[0] ? mag_b[XLEN-1:HW] : mag_b[HW-1:0];
    case (step)
      2'd0:    partial = {{XLEN{1'b0}}, prod};
      2'd3:    partial = {{XLEN{1'b0}}, prod} << XLEN;
      default: partial = {{XLEN{1'b0}}, prod} << HW;
    endcase
  end

  sub_mul #(.W(HW), .use_dsp(USE_DSP)) u_sub_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  logic [2*XLEN-1:0] fixed;
  logic [XLEN-1:0]   result;

  always_comb begin
    fixed = neg ? -acc : acc;
    if (is_w)
      result = {{(XLEN-32){fixed[31]}}, fixed[31:0]};
    else if (op_r == OP_MUL)
      result = fixed[XLEN-1:0];
    else
      result = fixed[2*XLEN-1:XLEN];
  end

  // NOTE: every register here uses <= so all updates see pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset clears the whole datapath so no stale operand or result is ever observable.
      state    <= IDLE;
      step     <= '0;
      acc      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg      <= 1'b0;
      is_w     <= 1'b0;
      op_r     <= '0;
      tag_r    <= '0;
      out_data <= '0;
      out_tag  <= '0;
`ifdef MUL_EARLY_OUT_EN
      early    <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r  <= in_op;
          is_w  <= w_in;
          tag_r <= in_tag;
          mag_a <= mag_a_in;
          mag_b <= mag_b_in;
          neg   <= sa_in ^ sb_in;
          acc   <= '0;
          step  <= '0;
`ifdef MUL_EARLY_OUT_EN
          early <= early_in;
`endif
          state <= CALC;
        end
        CALC: begin
          acc  <= acc + partial;
          step <= step + 2'd1;
`ifdef MUL_EARLY_OUT_EN
          if (step == 2'd3 || early) state <= FIX;
`else
          if (step == 2'd3) state <= FIX;
`endif
        end
        FIX: begin
          out_data <= result;
          out_tag  <= tag_r;
          state    <= DONE;
        end
        DONE:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// Unsigned W x W multiplier; use_dsp selects the native operator versus an explicit shift-add array.
module sub_mul #(
  parameter int W       = 32,
  parameter int use_dsp = 0
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  generate
    if (use_dsp != 0) begin : g_dsp
      assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end else begin : g_fabric
      always_comb begin
        p = '0;
        for (int i = 0; i < W; i++)
          if (b[i]) p = p + ({{W{1'b0}}, a} << i);
      end
    end
  endgenerate

endmodule
